// File: rtl/mips_wb_pkg.sv
// rtl/mips_wb_pkg.sv - shared encodings and state type for the MIPS write-back stage
//
// Purpose: write-back source selects, load sizes, register-file write-enable
//          codes and the write-back FSM state type.
// Ports:   none (package).
package mips_wb_pkg;

    // mem_to_reg encodings; 2'b11 is reserved and behaves like WB_SRC_ALU
    localparam logic [1:0] WB_SRC_ALU  = 2'b00;
    localparam logic [1:0] WB_SRC_MEM  = 2'b01;
    localparam logic [1:0] WB_SRC_LINK = 2'b10;

    // load_size encodings; 2'b11 is reserved and behaves like LD_WORD
    localparam logic [1:0] LD_WORD = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_BYTE = 2'b10;

    // RegWrite encodings; bit 1 is never set
    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_WRITE = 2'b01;

    typedef enum logic [1:0] {
        EMPTY    = 2'b00,
        WAIT_MEM = 2'b01,
        COMMIT   = 2'b10
    } wb_state_e;

endpackage

// File: rtl/wb_stage_load_align.sv
// rtl/wb_stage_load_align.sv - byte/half/word load alignment and extension
//
// Purpose: selects the addressed byte or halfword from a little-endian
//          memory word and sign- or zero-extends it to DATA_W.
// Ports:
//   mem_rdata     in   DATA_W  raw data-memory read word
//   offset        in   2       byte offset within the word (address bits [1:0])
//   load_size     in   2       LD_WORD / LD_HALF / LD_BYTE (11 acts as word)
//   load_unsigned in   1       1 = zero-extend, 0 = sign-extend
//   aligned       out  DATA_W  extended load result
module load_align
    import mips_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        offset,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] aligned
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[{offset, 3'b000} +: 8];
        // Halfword loads ignore offset[0]; a misaligned half reads the enclosing half.
        half_sel = mem_rdata[{offset[1], 4'b0000} +: 16];

        case (load_size)
            LD_BYTE: aligned = load_unsigned ? {{(DATA_W-8){1'b0}}, byte_sel}
                                             : {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            LD_HALF: aligned = load_unsigned ? {{(DATA_W-16){1'b0}}, half_sel}
                                             : {{(DATA_W-16){half_sel[15]}}, half_sel};
            default: aligned = mem_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MIPS write-back stage with multi-cycle load wait
//
// Purpose: accepts retiring instructions from MEM, waits for the data-memory
//          response on loads, aligns load data, selects the write-back source
//          and drives the register-file write port plus a forwarding copy.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           MEM handshake; transfer when both high
//   reg_write_in, mem_to_reg,
//   dest_reg, alu_result,
//   pcPlus4, load_size,
//   load_unsigned                 retiring instruction fields
//   mem_rdata, mem_rvalid         data-memory response
//   RegWrite, write_reg,
//   write_data_reg                register-file write port (registered)
//   fwd_valid, fwd_reg, fwd_data  same-cycle copy for decode-stage forwarding
//   stall_out                     upstream freeze request (!in_ready)
module wb_stage
    import mips_wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 reg_write_in,
    input  logic [1:0]           mem_to_reg,
    input  logic [REG_IDX_W-1:0] dest_reg,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [31:0]          pcPlus4,
    input  logic [1:0]           load_size,
    input  logic                 load_unsigned,
    input  logic [DATA_W-1:0]    mem_rdata,
    input  logic                 mem_rvalid,
    output logic [1:0]           RegWrite,
    output logic [31:0]          write_reg,
    output logic [DATA_W-1:0]    write_data_reg,
    output logic                 fwd_valid,
    output logic [REG_IDX_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]    fwd_data,
    output logic                 stall_out
);

    wb_state_e            state_q;
    logic [1:0]           reg_write_q;
    logic [REG_IDX_W-1:0] write_reg_q;
    logic [DATA_W-1:0]    write_data_q;

    // Load fields held while waiting on the memory response
    logic [REG_IDX_W-1:0] ld_dest_q;
    logic                 ld_wen_q;
    logic [1:0]           ld_off_q;
    logic [1:0]           ld_size_q;
    logic                 ld_unsigned_q;

    logic                 accept;
    logic                 is_load;
    logic                 wen_in;
    logic [DATA_W-1:0]    src_data;
    logic [DATA_W-1:0]    aligned;

    assign in_ready = (state_q != WAIT_MEM);
    assign accept   = in_valid && in_ready;
    // Only register-writing loads wait for memory, so a store never stalls here.
    assign is_load  = (mem_to_reg == WB_SRC_MEM) && reg_write_in;
    assign wen_in   = reg_write_in && (dest_reg != '0);

    always_comb begin
        case (mem_to_reg)
            WB_SRC_LINK: src_data = DATA_W'(pcPlus4);
            default:     src_data = alu_result;
        endcase
    end

    load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .mem_rdata     (mem_rdata),
        .offset        (ld_off_q),
        .load_size     (ld_size_q),
        .load_unsigned (ld_unsigned_q),
        .aligned       (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            reg_write_q   <= RW_IDLE;
            write_reg_q   <= '0;
            write_data_q  <= '0;
            ld_dest_q     <= '0;
            ld_wen_q      <= 1'b0;
            ld_off_q      <= '0;
            ld_size_q     <= LD_WORD;
            ld_unsigned_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY, COMMIT: begin
                    // Write enable is a one-cycle pulse; data/index hold between commits.
                    reg_write_q <= RW_IDLE;
                    if (accept && is_load) begin
                        state_q       <= WAIT_MEM;
                        ld_dest_q     <= dest_reg;
                        ld_wen_q      <= wen_in;
                        ld_off_q      <= alu_result[1:0];
                        ld_size_q     <= load_size;
                        ld_unsigned_q <= load_unsigned;
                    end else if (accept) begin
                        state_q      <= COMMIT;
                        reg_write_q  <= wen_in ? RW_WRITE : RW_IDLE;
                        write_reg_q  <= dest_reg;
                        write_data_q <= src_data;
                    end else begin
                        state_q <= EMPTY;
                    end
                end
                WAIT_MEM: begin
                    reg_write_q <= RW_IDLE;
                    if (mem_rvalid) begin
                        state_q      <= COMMIT;
                        reg_write_q  <= ld_wen_q ? RW_WRITE : RW_IDLE;
                        write_reg_q  <= ld_dest_q;
                        write_data_q <= aligned;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    reg_write_q <= RW_IDLE;
                end
            endcase
        end
    end

    assign RegWrite       = reg_write_q;
    assign write_reg      = 32'(write_reg_q);
    assign write_data_reg = write_data_q;
    assign fwd_valid      = reg_write_q[0];
    assign fwd_reg        = write_reg_q;
    assign fwd_data       = write_data_q;
    assign stall_out      = !in_ready;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        reg_write_in;
    logic [1:0]  mem_to_reg;
    logic [4:0]  dest_reg;
    logic [31:0] alu_result;
    logic [31:0] pcPlus4;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [1:0]  RegWrite;
    logic [31:0] write_reg;
    logic [31:0] write_data_reg;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        stall_out;

    int checks = 0;
    int errors = 0;

    wb_stage #(.DATA_W(32), .REG_IDX_W(5)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .reg_write_in   (reg_write_in),
        .mem_to_reg     (mem_to_reg),
        .dest_reg       (dest_reg),
        .alu_result     (alu_result),
        .pcPlus4        (pcPlus4),
        .load_size      (load_size),
        .load_unsigned  (load_unsigned),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .RegWrite       (RegWrite),
        .write_reg      (write_reg),
        .write_data_reg (write_data_reg),
        .fwd_valid      (fwd_valid),
        .fwd_reg        (fwd_reg),
        .fwd_data       (fwd_data),
        .stall_out      (stall_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] m2r, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [1:0] sz, input logic uns);
        in_valid      = v;
        reg_write_in  = rw;
        mem_to_reg    = m2r;
        dest_reg      = dest;
        alu_result    = alu;
        pcPlus4       = pc;
        load_size     = sz;
        load_unsigned = uns;
    endtask

    task automatic check_commit(input string tag, input logic [1:0] rw, input logic [4:0] dest,
                                input logic [31:0] data);
        check({tag, "_regwrite"}, 32'(RegWrite), 32'(rw));
        check({tag, "_write_reg"}, write_reg, 32'(dest));
        check({tag, "_write_data"}, write_data_reg, data);
        check({tag, "_fwd_valid"}, 32'(fwd_valid), 32'(rw[0]));
        check({tag, "_fwd_reg"}, 32'(fwd_reg), 32'(dest));
        check({tag, "_fwd_data"}, fwd_data, data);
    endtask

    // Accept a load, hold mem_rvalid low for 'waits' cycles, then return it with rdata.
    task automatic do_load(input string tag, input logic [4:0] dest, input logic [31:0] alu,
                           input logic [1:0] sz, input logic uns, input logic [31:0] rdata,
                           input int waits);
        drive(1'b1, 1'b1, 2'b01, dest, alu, 32'h0, sz, uns);
        tick;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd0);
        check({tag, "_stall_wait"}, 32'(stall_out), 32'd1);
        for (int i = 0; i < waits; i++) begin
            tick;
            check({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
            check({tag, "_no_early_write"}, 32'(RegWrite), 32'd0);
        end
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        tick;
        mem_rvalid = 1'b0;
        check({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        mem_rdata  = 32'h0;
        mem_rvalid = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick;
        tick;
        check_commit("reset", 2'b00, 5'd0, 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_stall", 32'(stall_out), 32'd0);
        rst = 1'b0;

        // ALU op commits one cycle after accept, enable pulses once
        drive(1'b1, 1'b1, 2'b00, 5'd5, 32'h0000_1234, 32'h0, 2'b00, 1'b0);
        tick;
        check_commit("alu", 2'b01, 5'd5, 32'h0000_1234);
        check("alu_in_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick;
        check_commit("alu_idle", 2'b00, 5'd5, 32'h0000_1234);

        // mem_rvalid while EMPTY must be ignored
        mem_rdata  = 32'hDEAD_BEEF;
        mem_rvalid = 1'b1;
        tick;
        mem_rvalid = 1'b0;
        check_commit("stray_rvalid", 2'b00, 5'd5, 32'h0000_1234);

        // Signed byte load, offset 1, three-cycle memory latency
        do_load("lb", 5'd8, 32'h0000_0101, 2'b10, 1'b0, 32'h0000_8000, 2);
        check_commit("lb", 2'b01, 5'd8, 32'hFFFF_FF80);

        // Unsigned half load, offset 2
        do_load("lhu", 5'd9, 32'h0000_0002, 2'b01, 1'b1, 32'hBEEF_0000, 0);
        check_commit("lhu", 2'b01, 5'd9, 32'h0000_BEEF);

        // Signed half load, offset 0
        do_load("lh", 5'd10, 32'h0000_0000, 2'b01, 1'b0, 32'h1234_8001, 1);
        check_commit("lh", 2'b01, 5'd10, 32'hFFFF_8001);

        // Unsigned byte load, offset 3
        do_load("lbu", 5'd11, 32'h0000_0003, 2'b10, 1'b1, 32'hA500_0000, 0);
        check_commit("lbu", 2'b01, 5'd11, 32'h0000_00A5);

        // Reserved load size behaves as a word
        do_load("lw_rsv", 5'd12, 32'h0000_0002, 2'b11, 1'b0, 32'h8765_4321, 0);
        check_commit("lw_rsv", 2'b01, 5'd12, 32'h8765_4321);

        // Load to $0 waits for memory but never writes
        do_load("lw_r0", 5'd0, 32'h0, 2'b00, 1'b0, 32'h1111_2222, 0);
        check("lw_r0_regwrite", 32'(RegWrite), 32'd0);

        // jal link write, then ALU op to $0 back to back
        drive(1'b1, 1'b1, 2'b10, 5'd31, 32'h0000_0999, 32'h0000_0040, 2'b00, 1'b0);
        tick;
        check_commit("jal", 2'b01, 5'd31, 32'h0000_0040);
        drive(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0055, 32'h0, 2'b00, 1'b0);
        tick;
        check("r0_regwrite", 32'(RegWrite), 32'd0);
        check("r0_fwd_valid", 32'(fwd_valid), 32'd0);

        // Store (no reg write) passes straight through without waiting on memory
        drive(1'b1, 1'b0, 2'b01, 5'd4, 32'h0000_0100, 32'h0, 2'b00, 1'b0);
        tick;
        check("store_regwrite", 32'(RegWrite), 32'd0);
        check("store_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ALU ops at full throughput
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b1, 2'b00, 5'(i), 32'(i * 32'h11), 32'h0, 2'b00, 1'b0);
            tick;
            check_commit("b2b", 2'b01, 5'(i), 32'(i * 32'h11));
            check("b2b_in_ready", 32'(in_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        tick;
        check("b2b_idle", 32'(RegWrite), 32'd0);

        // Reset during WAIT_MEM drops the load; a late response is ignored
        drive(1'b1, 1'b1, 2'b01, 5'd12, 32'h0, 32'h0, 2'b00, 1'b0);
        tick;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        check("rstw_in_ready_wait", 32'(in_ready), 32'd0);
        tick;
        rst = 1'b1;
        tick;
        rst        = 1'b0;
        check_commit("rstw_reset", 2'b00, 5'd0, 32'h0);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        mem_rdata  = 32'hFFFF_FFFF;
        mem_rvalid = 1'b1;
        tick;
        mem_rvalid = 1'b0;
        check_commit("rstw_late", 2'b00, 5'd0, 32'h0);
        check("rstw_late_in_ready", 32'(in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage MIPS pipeline: the writer-side counterpart of the decode stage's register-file read port.
- Accepts retiring instructions from MEM and waits on multi-cycle data-memory responses for loads.
- Aligns and extends load data, selects the write-back source.
- Drives the register-file write port (RegWrite, write_reg, write_data_reg) plus a same-cycle forwarding copy for the decode-stage comparator.

Parameters:
- DATA_W, 32, datapath width.
- REG_IDX_W, 5, register index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM offers an instruction this cycle
- in_ready  out  1  stage accepts; transfer when in_valid && in_ready
- reg_write_in  in  1  instruction writes a register
- mem_to_reg  in  2  source select: 00 ALU, 01 load data, 10 link (pcPlus4), 11 reserved (treated as 00)
- dest_reg  in  REG_IDX_W  destination index
- alu_result  in  DATA_W  ALU result; bits [1:0] are the load byte offset
- pcPlus4  in  32  link value
- load_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as word)
- load_unsigned  in  1  1 = zero-extend, 0 = sign-extend
- mem_rdata  in  DATA_W  data-memory read word
- mem_rvalid  in  1  mem_rdata valid this cycle
- RegWrite  out  2  register-file write enable: 2'b01 write, 2'b00 idle; bit1 always 0
- write_reg  out  32  destination index, zero-extended
- write_data_reg  out  DATA_W  write data
- fwd_valid  out  1  equals RegWrite[0]
- fwd_reg  out  REG_IDX_W  equals write_reg[REG_IDX_W-1:0]
- fwd_data  out  DATA_W  equals write_data_reg
- stall_out  out  1  equals !in_ready; upstream freeze request

Behaviour:
- Reset: state EMPTY; RegWrite=0, write_reg=0, write_data_reg=0, fwd_*=0, in_ready=1; any pending load is discarded.
- FSM states are EMPTY, WAIT_MEM and COMMIT.
  - EMPTY/COMMIT, accepted non-load (mem_to_reg != 01): next state COMMIT; outputs registered from the captured fields.
  - EMPTY/COMMIT, accepted load: next state WAIT_MEM; fields captured.
  - EMPTY/COMMIT, nothing accepted: next state EMPTY.
  - WAIT_MEM: in_ready=0. On mem_rvalid, the aligned data is registered and the next state is COMMIT; otherwise hold.
- Latency:
  - Non-load accepted in cycle N commits in cycle N+1.
  - Load accepted in cycle N with mem_rvalid in cycle K (K >= N+1) commits in cycle K+1.
- Throughput: one instruction per cycle for non-loads; back-to-back accept is allowed in COMMIT.
- Commit cycle:
  - RegWrite=2'b01 for exactly one cycle if reg_write_in && dest_reg != 0; otherwise 2'b00.
  - write_reg and write_data_reg hold their values until the next commit.
- Writes to $0 are always suppressed, including link and load.
- mem_rvalid outside WAIT_MEM is ignored.
- Accepted instruction with reg_write_in=0: passes through COMMIT with RegWrite=0; a store never enters WAIT_MEM.
- Load alignment, where off = alu_result[1:0]:
  - byte = mem_rdata[8*off +: 8]
  - half = mem_rdata[16*off[1] +: 16]
  - word = mem_rdata
  - Extension per load_unsigned.
- Link: write_data_reg = pcPlus4 captured at accept.
- Synchronous reset during WAIT_MEM: the load is dropped, no commit follows, and a late mem_rvalid is ignored.

Decomposition:
- Package mips_wb_pkg holds:
  - mem_to_reg encodings WB_SRC_ALU/MEM/LINK
  - load_size encodings LD_WORD/HALF/BYTE
  - RegWrite encodings
  - the state enum EMPTY/WAIT_MEM/COMMIT
- One combinational sub-module, load_align: inputs mem_rdata, offset, load_size, load_unsigned; output the extended word.

Test Plan:
1. ALU op: accept dest=5, alu_result=0x0000_1234, mem_to_reg=00 in cycle 3 -> cycle 4 RegWrite=01, write_reg=5, write_data_reg=0x1234, fwd_valid=1; cycle 5 RegWrite=00.
2. Signed byte load: dest=8, alu_result=...01, load_size=10, load_unsigned=0; mem_rvalid 3 cycles later with rdata=0x0000_8000 -> in_ready=0 while waiting; commit data 0xFFFF_FF80 one cycle after mem_rvalid.
3. Unsigned half load: off=2, rdata=0xBEEF_0000, load_unsigned=1 -> write_data_reg=0x0000_BEEF.
4. Link and $0 suppression:
   - jal with dest=31, pcPlus4=0x40 -> write_data_reg=0x40.
   - Next, ALU op with dest=0 -> RegWrite stays 00.
5. Back-to-back ALU ops in cycles 2, 3, 4 -> RegWrite=01 in cycles 3, 4, 5 with matching data; in_ready stays 1 throughout.
6. rst asserted during WAIT_MEM, then mem_rvalid the following cycle -> no write; outputs 0; state EMPTY; in_ready=1.
